pla_seq_eval: RTL

//  Parametrised, sequential successor to our flat single-output PLA netlists.

---
 rtl/pla_seq_eval.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/pla_seq_eval.sv
// Sequential AND/OR cube-table evaluator: scans LANES cubes per cycle and returns
// function bits plus a matched-cube count. Optional AUTOSYM_EN adds an input translation register.
module pla_seq_eval #(
  parameter int N_IN    = 24,
  parameter int N_OUT   = 1,
  parameter int N_CUBES = 16,
  parameter int LANES   = 4,
  localparam int AW     = (N_CUBES > 1) ? $clog2(N_CUBES) : 1,
  localparam int HW     = $clog2(N_CUBES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [2*N_IN-1:0] cfg_inpl,
  input  logic [N_OUT-1:0]  cfg_outpl,
  output logic              cfg_err,
`ifdef AUTOSYM_EN
  input  logic              xlat_we,
  input  logic [N_IN-1:0]   xlat_val,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_y,
  output logic [HW-1:0]     out_hits
);

  localparam int S  = (N_CUBES + LANES - 1) / LANES;
  localparam int GW = $clog2(S + 1);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t            state_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic              cfg_err_reg;
  logic [N_IN-1:0]   x_reg;
  logic [N_OUT-1:0]  acc_reg;
  logic [HW-1:0]     hits_reg;
  logic [GW-1:0]     grp_reg;
  logic              pipe_vld_reg;
  logic              pipe_last_reg;
  logic [N_OUT-1:0]  pipe_or_reg;
  logic [HW-1:0]     pipe_cnt_reg;
  logic              pend_vld_reg;
  logic [AW-1:0]     pend_addr_reg;
  logic [2*N_IN-1:0] pend_inpl_reg;
  logic [N_OUT-1:0]  pend_outpl_reg;
`ifdef AUTOSYM_EN
  logic [N_IN-1:0]   xlat_reg;
`endif

  logic [2*N_IN-1:0] inpl_mem  [N_CUBES];
  logic [N_OUT-1:0]  outpl_mem [N_CUBES];

  logic              addr_ok;
  logic              cfg_reject;
  logic              issue;
  logic              tbl_we;
  logic [AW-1:0]     tbl_addr;
  logic [2*N_IN-1:0] tbl_inpl;
  logic [N_OUT-1:0]  tbl_outpl;
  logic [LANES-1:0]  lane_hit;
  logic [N_OUT-1:0]  lane_or [LANES];
  logic [N_OUT-1:0]  step_or;
  logic [HW-1:0]     step_cnt;

  assign addr_ok = int'(cfg_addr) < N_CUBES;
  assign issue   = grp_reg < GW'(S);

`ifdef AUTOSYM_EN
  assign cfg_reject = (cfg_we && (state_reg != IDLE || !addr_ok)) ||
                      (xlat_we && state_reg != IDLE);
`else
  assign cfg_reject = cfg_we && (state_reg != IDLE || !addr_ok);
`endif

  // A write that coincides with an accept is parked and committed when the
  // block returns to IDLE, so the in-flight vector still sees the old table.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_addr  = cfg_addr;
    tbl_inpl  = cfg_inpl;
    tbl_outpl = cfg_outpl;
    if (state_reg == IDLE && cfg_we && addr_ok && !in_valid) begin
      tbl_we = 1'b1;
    end else if (state_reg == DONE && out_ready && pend_vld_reg) begin
      tbl_we    = 1'b1;
      tbl_addr  = pend_addr_reg;
      tbl_inpl  = pend_inpl_reg;
      tbl_outpl = pend_outpl_reg;
    end
  end

  // Table must clear on reset and feed LANES entries in parallel, so it lives in flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CUBES; i++) begin
        inpl_mem[i]  <= '0;
        outpl_mem[i] <= '0;
      end
    end else if (tbl_we) begin
      inpl_mem[tbl_addr]  <= tbl_inpl;
      outpl_mem[tbl_addr] <= tbl_outpl;
    end
  end

  genvar gi, gv;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [31:0]       cidx;
      logic              lane_in;
      logic [AW-1:0]     sel;
      logic [2*N_IN-1:0] pl;
      logic [N_IN-1:0]   var_ok;

      assign cidx    = 32'(grp_reg) * 32'(LANES) + 32'(gi);
      assign lane_in = cidx < 32'(N_CUBES);
      assign sel     = lane_in ? cidx[AW-1:0] : '0;
      assign pl      = inpl_mem[sel];

      // Code bit 1 admits x=1, bit 0 admits x=0; a 00 pair admits nothing.
      for (gv = 0; gv < N_IN; gv++) begin : g_var
        assign var_ok[gv] = x_reg[gv] ? pl[2*gv+1] : pl[2*gv];
      end

      assign lane_hit[gi] = lane_in & (&var_ok);
      assign lane_or[gi]  = lane_hit[gi] ? outpl_mem[sel] : '0;
    end
  endgenerate

  always_comb begin
    step_or  = '0;
    step_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      step_or  = step_or | lane_or[i];
      step_cnt = step_cnt + HW'(lane_hit[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      cfg_err_reg    <= 1'b0;
      x_reg          <= '0;
      acc_reg        <= '0;
      hits_reg       <= '0;
      grp_reg        <= '0;
      pipe_vld_reg   <= 1'b0;
      pipe_last_reg  <= 1'b0;
      pipe_or_reg    <= '0;
      pipe_cnt_reg   <= '0;
      pend_vld_reg   <= 1'b0;
      pend_addr_reg  <= '0;
      pend_inpl_reg  <= '0;
      pend_outpl_reg <= '0;
`ifdef AUTOSYM_EN
      xlat_reg       <= '0;
`endif
    end else begin
      cfg_err_reg <= cfg_reject;
      case (state_reg)
        IDLE: begin
`ifdef AUTOSYM_EN
          if (xlat_we) xlat_reg <= xlat_val;
`endif
          if (in_valid) begin
`ifdef AUTOSYM_EN
            x_reg <= in_x ^ xlat_reg;
`else
            x_reg <= in_x;
`endif
            acc_reg      <= '0;
            hits_reg     <= '0;
            grp_reg      <= '0;
            pipe_vld_reg <= 1'b0;
            in_ready_reg <= 1'b0;
            state_reg    <= EVAL;
            if (cfg_we && addr_ok) begin
              pend_vld_reg   <= 1'b1;
              pend_addr_reg  <= cfg_addr;
              pend_inpl_reg  <= cfg_inpl;
              pend_outpl_reg <= cfg_outpl;
            end
          end
        end
        EVAL: begin
          pipe_vld_reg  <= issue;
          pipe_last_reg <= issue && (grp_reg == GW'(S - 1));
          pipe_or_reg   <= step_or;
          pipe_cnt_reg  <= step_cnt;
          if (issue) grp_reg <= grp_reg + 1'b1;
          if (pipe_vld_reg) begin
            acc_reg  <= acc_reg | pipe_or_reg;
            hits_reg <= hits_reg + pipe_cnt_reg;
            if (pipe_last_reg) begin
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            pend_vld_reg  <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_y     = acc_reg;
  assign out_hits  = hits_reg;
  assign cfg_err   = cfg_err_reg;

endmodule
